ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction-fetch stage that drives the instruction memory's word address and consumes its combinational read data.
- Owns the program counter and buffers fetched words in a small in-order queue.
- Presents {instr, pc} pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute; a redirect flushes everything fetched but not yet handed over.

Parameters:
- n, 32 (`WORDSIZE), instruction and PC width in bits.
- r, 7, instruction-memory word-address width; must match the instruction memory's r.
- DEPTH, 2, fetch-queue entries; power of two, >= 2.
- RESET_PC, 0, byte address fetched first after reset.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  r  word address to instruction memory = pc[r+1:2].
- imem_readdata  in  n  combinational instruction word for imem_addr, same cycle.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  n  target byte address; bits [1:0] are ignored (forced 0).
- instr_valid  out  1  head queue entry available to decode.
- instr_ready  in  1  decode accepts the head entry this cycle.
- instr  out  n  instruction word of the head entry.
- instr_pc  out  n  byte address of the head entry.

Behaviour:
- Reset (reset==0 at posedge): pc<=RESET_PC, queue emptied, pointers/count<=0. While the queue is empty the outputs are instr_valid=0, instr=0, instr_pc=0; the empty-queue outputs are driven to 0, not stale entry data.
- Combinational outputs:
  - imem_addr=pc[r+1:2] every cycle, including during reset.
  - Upper PC bits are ignored, so the address wraps modulo 2**r words.
- pop = instr_valid & instr_ready.
- push = !full | pop, when redirect_valid==0. Each push writes {imem_readdata, pc} at the tail and sets pc<=pc+4 (n-bit wrap; 0xFFFFFFFC+4=0).
- Simultaneous push and pop: allowed when full, so throughput is 1 instr/cycle with instr_ready held high.
- Latency: a word fetched in cycle k is presented with instr_valid=1 in cycle k+1 (queue was empty). After reset deasserts, the first instruction is valid on the 2nd posedge.
- Stall: with instr_ready=0, the queue fills to DEPTH and then pc holds. The head entry and instr_valid stay stable until accepted; they must not change while valid & !ready.
- Redirect (redirect_valid==1):
  - instr_valid is forced 0 combinationally, so no transfer occurs that cycle.
  - At posedge the queue is flushed (count<=0), there is no push, and pc<={redirect_pc[n-1:2],2'b00}.
  - The first target instruction is valid 2 cycles after the redirect cycle.
- Redirect while full or empty: same behaviour, flush always wins.
- Back-to-back redirects: the last one wins.
- Reset vs redirect in the same cycle: reset wins.
- Queue is a circular buffer with head/tail pointers of log2(DEPTH) bits, wrapping at DEPTH, plus a count of log2(DEPTH)+1 bits.
  - full = count==DEPTH; empty = count==0.
  - count never exceeds DEPTH or goes below 0.

Decomposition:
- Shared package:
  - typedef fetch_entry_t = struct {logic [n-1:0] instr; logic [n-1:0] pc;}
  - constant INSTR_BYTES=4.
- Sub-module fetch_queue: parametrised FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: head, full, empty.
  - Same clk/reset.
- ifetch keeps the PC register, the push/redirect control and the address slice.

Test Plan:
1. Reset, RESET_PC=0, imem preloaded words 0x11,0x22,0x33, instr_ready=1 -> imem_addr=0 during reset; after release instr/instr_pc = 0x11/0x0, 0x22/0x4, 0x33/0x8 on consecutive cycles, no bubbles.
2. instr_ready=0 for 5 cycles after the first valid -> queue holds 2 entries, pc frozen at 0x8, instr=0x11 stable. On ready=1, 0x11 then 0x22 then 0x33 follow with no loss or duplication.
3. Queue full, redirect_valid=1, redirect_pc=0x43 -> instr_valid=0 that cycle, next pc=0x40, imem_addr=0x10. Next valid is RAM[0x10] with instr_pc=0x40; old entries never appear.
4. PC wrap: redirect to byte 0x1FC with r=7 -> entries at pc 0x1FC then 0x200, with imem_addr 0x7F then 0x00.
5. Assert reset mid-stream with the queue holding 1 entry -> next cycle instr_valid=0, pc=RESET_PC, and fetch restarts exactly as in scenario 1.
6. Random ready/redirect, 10k cycles, against a reference model -> every accepted instr_pc sequence matches sequential-PC-plus-redirect semantics and count stays in 0..DEPTH.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// A fetch entry pairs an instruction word with the byte address it came from.
package ifetch_pkg;

    localparam int WORDSIZE    = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [WORDSIZE-1:0] instr;
        logic [WORDSIZE-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries with flush.
// Head reads as zero while empty so decode never sees stale entry data.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[head_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= wdata;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle into the
// queue and hands {instr, pc} to decode; execute redirects flush the queue.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int          n        = WORDSIZE,
    parameter int          r        = 7,
    parameter int          DEPTH    = 2,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [r-1:0] imem_addr,
    input  logic [n-1:0] imem_readdata,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc
);

    logic [n-1:0] pc_q, pc_d;
    logic         push, pop, full, empty;
    fetch_entry_t wdata, head;

    assign imem_addr = pc_q[r+1:2];

    // A redirect suppresses the handshake so nothing stale leaks into decode.
    assign instr_valid = !empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = !redirect_valid && (!full || pop);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign wdata       = '{instr: imem_readdata, pc: pc_q};

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = redirect_pc & {{(n-2){1'b1}}, 2'b00};
        else if (push)
            pc_d = pc_q + n'(INSTR_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) uQueue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a reference PC/queue model predicts every
// fetched entry and checks it when decode accepts it.
module tb_ifetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  imem_addr;
    logic [31:0] imem_readdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic [31:0] imem [128];
    assign imem_readdata = imem[imem_addr];

    always #5 clk = ~clk;

    ifetch #(
        .n(32), .r(7), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_readdata  (imem_readdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } expEntry_t;

    expEntry_t   sb[$];
    expEntry_t   acceptLog[$];
    logic [31:0] modelPc;
    int          total = 0;
    int          bad   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at negedge, compare against the model, then
    // advance the model to what the coming posedge should produce.
    task automatic applyStimulus(input logic rstN, input logic ready,
                                 input logic redir, input logic [31:0] rpc);
        expEntry_t e;
        logic      expValid, accept, wasFull;
        @(negedge clk);
        reset          = rstN;
        instr_ready    = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        expValid = (sb.size() != 0) && !redir;
        checkOutput("imem_addr", 32'(imem_addr), 32'(modelPc[8:2]));
        checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
        checkOutput("count", 32'(dut.uQueue.count_q), sb.size());
        if (sb.size() == 0) begin
            checkOutput("empty_instr", instr, 32'h0);
            checkOutput("empty_pc", instr_pc, 32'h0);
        end else if (expValid) begin
            checkOutput("head_instr", instr, sb[0].instr);
            checkOutput("head_pc", instr_pc, sb[0].pc);
        end
        accept = expValid && ready;
        if (instr_valid && ready) begin
            e.instr = instr;
            e.pc    = instr_pc;
            acceptLog.push_back(e);
        end
        if (!rstN) begin
            sb.delete();
            modelPc = 32'h0;
        end else if (redir) begin
            sb.delete();
            modelPc = {rpc[31:2], 2'b00};
        end else begin
            wasFull = (sb.size() == DEPTH);
            if (accept) e = sb.pop_front();
            if (!wasFull || accept) begin
                e.instr = imem[modelPc[8:2]];
                e.pc    = modelPc;
                sb.push_back(e);
                modelPc = modelPc + 32'd4;
            end
        end
    endtask

    task automatic checkLog(input string tag, input int idx,
                            input logic [31:0] expInstr, input logic [31:0] expPc);
        if (idx < acceptLog.size()) begin
            checkOutput({tag, "_instr"}, acceptLog[idx].instr, expInstr);
            checkOutput({tag, "_pc"}, acceptLog[idx].pc, expPc);
        end else begin
            checkOutput({tag, "_missing"}, 32'(acceptLog.size()), 32'(idx + 1));
        end
    endtask

    task automatic runReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        acceptLog.delete();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) imem[i] = 32'hA000_0000 + 32'(i) * 32'h0001_0101;
        imem[0] = 32'h11;
        imem[1] = 32'h22;
        imem[2] = 32'h33;

        reset          = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clk);
        modelPc = 32'h0;
        sb.delete();

        $display("[TB] scenario 1: reset and streaming");
        runReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("s1_len", 32'(acceptLog.size()), 32'd3);
        checkLog("s1_0", 0, 32'h11, 32'h0);
        checkLog("s1_1", 1, 32'h22, 32'h4);
        checkLog("s1_2", 2, 32'h33, 32'h8);

        $display("[TB] scenario 2: stall");
        runReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("s2_addr_frozen", 32'(imem_addr), 32'h2);
        checkOutput("s2_head", instr, 32'h11);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("s2_len", 32'(acceptLog.size()), 32'd3);
        checkLog("s2_0", 0, 32'h11, 32'h0);
        checkLog("s2_1", 1, 32'h22, 32'h4);
        checkLog("s2_2", 2, 32'h33, 32'h8);

        $display("[TB] scenario 3: redirect while full");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        acceptLog.delete();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h43);
        @(posedge clk); #1;
        checkOutput("s3_addr", 32'(imem_addr), 32'h10);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkLog("s3_first", 0, imem[16], 32'h40);

        $display("[TB] scenario 4: pc wrap");
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h1FC);
        acceptLog.delete();
        @(posedge clk); #1;
        checkOutput("s4_addr_7f", 32'(imem_addr), 32'h7F);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        checkOutput("s4_addr_00", 32'(imem_addr), 32'h00);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkLog("s4_0", 0, imem[127], 32'h1FC);
        checkLog("s4_1", 1, imem[0], 32'h200);

        $display("[TB] scenario 5: reset mid-stream");
        checkOutput("s5_count_before", 32'(dut.uQueue.count_q), 32'd1);
        runReset();
        @(posedge clk); #1;
        checkOutput("s5_valid", 32'(instr_valid), 32'd0);
        checkOutput("s5_addr", 32'(imem_addr), 32'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkLog("s5_0", 0, 32'h11, 32'h0);
        checkLog("s5_1", 1, 32'h22, 32'h4);
        checkLog("s5_2", 2, 32'h33, 32'h8);

        $display("[TB] scenario 6: random traffic");
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0,
                          $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
